// File: rtl/dual_port_ram_pkg.sv
// Shared constants for the dual-port RAM: default word/address widths and depth.
package dual_port_ram_pkg;

  localparam int DPRAM_DATA_WIDTH = 8;
  localparam int DPRAM_ADDR_WIDTH = 6;
  localparam int DPRAM_DEPTH      = 2 ** DPRAM_ADDR_WIDTH;

endpackage

// File: rtl/dpram_port.sv
// One RAM port's output register: write-first on its own write, otherwise the
// array word that was stored before this edge.
module dpram_port
  import dual_port_ram_pkg::*;
#(
  parameter int DATA_WIDTH = DPRAM_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      q <= we ? wdata : rd_data;
    end
  end

endmodule

// File: rtl/dual_port_ram.sv
// True dual-port RAM, one clock, registered outputs. Port A wins a same-address
// write collision; cross-port reads see the contents from before the edge.
module dual_port_ram
  import dual_port_ram_pkg::*;
#(
  parameter int DATA_WIDTH = DPRAM_DATA_WIDTH,
  parameter int ADDR_WIDTH = DPRAM_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic                  we_a,
  output logic [DATA_WIDTH-1:0] q_a,
  input  logic [DATA_WIDTH-1:0] data_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic                  we_b,
  output logic [DATA_WIDTH-1:0] q_b
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // No reset on the array so it can map onto block RAM.
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  wr_a;
  logic                  wr_b;
  logic [DATA_WIDTH-1:0] rd_a;
  logic [DATA_WIDTH-1:0] rd_b;

  assign wr_a = rst_n && we_a;
  assign wr_b = rst_n && we_b && !(we_a && (addr_a == addr_b));

  always_ff @(posedge clk) begin
    if (wr_a) begin
      mem[addr_a] <= data_a;
    end
    if (wr_b) begin
      mem[addr_b] <= data_b;
    end
  end

  assign rd_a = mem[addr_a];
  assign rd_b = mem[addr_b];

  dpram_port #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_port_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (we_a),
    .wdata  (data_a),
    .rd_data(rd_a),
    .q      (q_a)
  );

  dpram_port #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_port_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (we_b),
    .wdata  (data_b),
    .rd_data(rd_b),
    .q      (q_b)
  );

endmodule

// File: tb/tb_dual_port_ram.sv
// Bench for dual_port_ram: directed corner cases plus random traffic against a
// word-array reference model that tracks which addresses hold defined data.
module tb_dual_port_ram;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] data_a = '0;
  logic [5:0] addr_a = '0;
  logic       we_a = 1'b0;
  logic [7:0] q_a;
  logic [7:0] data_b = '0;
  logic [5:0] addr_b = '0;
  logic       we_b = 1'b0;
  logic [7:0] q_b;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] ref_mem [64];
  bit         ref_ok  [64];

  dual_port_ram dut (
    .clk   (clk),
    .rst_n (rst_n),
    .data_a(data_a),
    .addr_a(addr_a),
    .we_a  (we_a),
    .q_a   (q_a),
    .data_b(data_b),
    .addr_b(addr_b),
    .we_b  (we_b),
    .q_b   (q_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%02h, want 0x%02h", tag, obs, exp);
    end
  endtask

  // One clock of access on both ports; expectations come from the model state
  // before the edge, then the model is updated (A's write lands last, so A wins).
  task automatic step(input string tag,
                      input logic wa, input logic [5:0] aa, input logic [7:0] da,
                      input logic wb, input logic [5:0] ab, input logic [7:0] db);
    logic [7:0] ea, eb;
    bit         ka, kb;
    we_a = wa; addr_a = aa; data_a = da;
    we_b = wb; addr_b = ab; data_b = db;
    if (!rst_n) begin
      ea = 8'h00; eb = 8'h00; ka = 1'b1; kb = 1'b1;
    end else begin
      ea = wa ? da : ref_mem[aa];
      ka = wa || ref_ok[aa];
      eb = wb ? db : ref_mem[ab];
      kb = wb || ref_ok[ab];
      if (wb) begin ref_mem[ab] = db; ref_ok[ab] = 1'b1; end
      if (wa) begin ref_mem[aa] = da; ref_ok[aa] = 1'b1; end
    end
    @(posedge clk);
    #1;
    if (ka) chk({tag, "_q_a"}, q_a, ea);
    if (kb) chk({tag, "_q_b"}, q_b, eb);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = '0;
      ref_ok[i]  = 1'b0;
    end

    // Asynchronous reset: outputs clear without any clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_q_a", q_a, 8'h00);
    chk("rst_async_q_b", q_b, 8'h00);
    step("rst_hold", 1'b0, 6'd0, 8'h00, 1'b0, 6'd0, 8'h00);
    step("rst_hold", 1'b0, 6'd0, 8'h00, 1'b0, 6'd0, 8'h00);
    rst_n = 1'b1;

    // Separate writes then read back on both ports.
    step("wr_a1",   1'b1, 6'd1, 8'h01, 1'b0, 6'd0, 8'h00);
    step("wr_b2",   1'b0, 6'd0, 8'h00, 1'b1, 6'd2, 8'h02);
    step("rd_12",   1'b0, 6'd1, 8'h00, 1'b0, 6'd2, 8'h00);

    // Cross-port read-during-write returns old data.
    step("xrdw",    1'b1, 6'd2, 8'h03, 1'b0, 6'd2, 8'h00);
    step("xrdw_rd", 1'b0, 6'd2, 8'h00, 1'b0, 6'd2, 8'h00);

    // Same-address write collision: A's data is stored.
    step("coll",    1'b1, 6'd5, 8'hAA, 1'b1, 6'd5, 8'h55);
    step("coll_rd", 1'b0, 6'd5, 8'h00, 1'b0, 6'd5, 8'h00);

    // Address boundaries.
    step("bnd_wr",  1'b1, 6'd0, 8'h3C, 1'b1, 6'd63, 8'hC3);
    step("bnd_rd",  1'b0, 6'd63, 8'h00, 1'b0, 6'd0, 8'h00);

    // Reset asserted mid-write at addr 7: write dropped, old 0x11 survives.
    step("pre7_wr", 1'b1, 6'd7, 8'h11, 1'b0, 6'd7, 8'h00);
    step("pre7_rd", 1'b0, 6'd7, 8'h00, 1'b0, 6'd7, 8'h00);
    we_a = 1'b1; addr_a = 6'd7; data_a = 8'h99;
    we_b = 1'b1; addr_b = 6'd7; data_b = 8'h66;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_q_a", q_a, 8'h00);
    chk("rst_mid_q_b", q_b, 8'h00);
    step("rst_blk", 1'b1, 6'd7, 8'h99, 1'b1, 6'd7, 8'h66);
    rst_n = 1'b1;
    step("post7_rd", 1'b0, 6'd7, 8'h00, 1'b0, 6'd7, 8'h00);

    // Random traffic, biased toward a few addresses to force collisions.
    for (int n = 0; n < 400; n++) begin
      logic       wa, wb;
      logic [5:0] aa, ab;
      logic [7:0] da, db;
      wa = 1'($urandom_range(0, 1));
      wb = 1'($urandom_range(0, 1));
      aa = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 3)) : 6'($urandom_range(0, 63));
      ab = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 3)) : 6'($urandom_range(0, 63));
      da = 8'($urandom);
      db = 8'($urandom);
      step("rand", wa, aa, da, wb, ab, db);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dual_port_ram.md
DUAL_PORT_RAM -- requirements
Module: dual_port_ram

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, which sets the word width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 6, which sets the address width; DEPTH = 2**ADDR_WIDTH = 64 words.
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 Port data_a  input  DATA_WIDTH  SHALL be the port A write data.
REQ-006 Port addr_a  input  ADDR_WIDTH  SHALL be the port A address, used for both read and write.
REQ-007 Port we_a  input  1  SHALL be the port A write enable, active-high.
REQ-008 Port q_a  output  DATA_WIDTH  SHALL be the registered port A read data.
REQ-009 Port data_b  input  DATA_WIDTH  SHALL be the port B write data.
REQ-010 Port addr_b  input  ADDR_WIDTH  SHALL be the port B address, used for both read and write.
REQ-011 Port we_b  input  1  SHALL be the port B write enable, active-high.
REQ-012 Port q_b  output  DATA_WIDTH  SHALL be the registered port B read data.

Function
REQ-013 Storage SHALL be one shared array of DEPTH words, fully accessible from both ports; every address is in range, so no wrap-around or bounds logic is needed.
REQ-014 On a rising clk edge with we_x=1, port x SHALL write data_x into mem[addr_x].
REQ-015 On every rising clk edge with we_x=0, port x SHALL load q_x with mem[addr_x]; read latency is exactly 1 cycle from address to q_x.
REQ-016 Same-port read-during-write SHALL be write-first: when we_x=1, q_x SHALL take data_x on that edge.
REQ-017 Cross-port read-during-write SHALL be read-before-write: when port x writes address N and port y reads address N on the same edge, q_y SHALL return the old contents of N; the new value is visible on the next read.
REQ-018 When both ports write the same address on the same edge, port A's data SHALL be stored.
REQ-019 In a simultaneous same-address write, q_a SHALL return data_a and q_b SHALL return data_b, each per REQ-016.
REQ-020 Writes to different addresses on the same edge SHALL both take effect.
REQ-021 q_a and q_b SHALL hold their value between clock edges; outputs SHALL contain no combinational path from inputs.
REQ-022 There SHALL be no handshake: every edge is one access per port, and there are no stall or busy conditions.

Reset
REQ-023 When rst_n=0, q_a and q_b SHALL clear to 0 asynchronously and stay at 0 while rst_n is low.
REQ-024 Memory contents SHALL NOT be reset, so the array can map to block RAM.
REQ-025 While rst_n=0, writes SHALL be blocked on both ports.
REQ-026 Contents after power-up SHALL be treated as undefined; a read before any write returns X in simulation.
REQ-027 If reset is asserted in the middle of an access, that access SHALL be dropped.
REQ-028 After rst_n deasserts, the first rising edge SHALL perform normal accesses.

Structure
REQ-029 The default widths and DEPTH SHALL be defined as constants in the shared package dual_port_ram_pkg.
REQ-030 One sub-module, dpram_port, SHALL hold the per-port output register and its read-during-write mux, and SHALL be instantiated once for A and once for B.
REQ-031 The memory array and the write arbitration of REQ-018 SHALL be implemented in dual_port_ram itself.

Verification
REQ-032 Reset with rst_n=0 for 2 cycles -> q_a=0x00 and q_b=0x00 immediately on assertion, with no clock edge required.
REQ-033 Write A: addr_a=1, data_a=0x01, we_a=1 for 1 cycle; then write B: addr_b=2, data_b=0x02, we_b=1 for 1 cycle; then both we=0 with addr_a=1, addr_b=2 -> one cycle later q_a=0x01 and q_b=0x02.
REQ-034 Port A writes 0x03 to addr 2 while port B reads addr 2 -> q_a=0x03 and q_b=0x02 that cycle; on the next read q_a=0x03 and q_b=0x03.
REQ-035 Both ports write addr 5 on the same edge, A=0xAA and B=0x55 -> a subsequent read on either port returns 0xAA.
REQ-036 Write 0x3C to addr 0 and 0xC3 to addr 63 -> reading them back returns 0x3C and 0xC3, which confirms the address boundaries.
REQ-037 Assert rst_n mid-write at addr 7, which previously held 0x11 -> outputs go to 0; after release, reading addr 7 returns 0x11.
